// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between two requesters, with a
// valid/ready response port, a running indication and a sticky error flag.
module alu_share_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int OP_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  input  logic              alu_error,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [15:0]       resp_data,
  output logic              resp_error,
  output logic              running,
  output logic              error_sticky,
  input  logic              error_clear
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       accept;
  logic       capture;

  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    accept    = (state == IDLE) && (req_valid != 2'b00);
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    capture   = (state == EXEC) && (cnt == 4'd1);
  end

  // last_grant resets to 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      last_grant   <= 1'b1;
      alu_op       <= '0;
      alu_a        <= 16'd0;
      alu_b        <= 16'd0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= 16'd0;
      resp_error   <= 1'b0;
      running      <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      if (capture && alu_error)
        error_sticky <= 1'b1;
      else if (error_clear)
        error_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            alu_op     <= grant ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
            alu_a      <= grant ? req_a[31:16] : req_a[15:0];
            alu_b      <= grant ? req_b[31:16] : req_b[15:0];
            resp_id    <= grant;
            last_grant <= grant;
            cnt        <= 4'(ALU_LAT);
            running    <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (capture) begin
            resp_data  <= alu_result;
            resp_error <= alu_error;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            running    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
